// File: rtl/v_block_pwm.sv
// v_block_pwm: per-zone-row backlight PWM enable, clocked once per line.
// Tracks which zone row the vertical scan is on and compares the in-row
// line phase against that row's duty from a double-buffered duty table.
// The active bank swaps only at frame start, so a frame never mixes duties.
// Optional build macro: V_BLOCK_PWM_MIN_DUTY_EN applies a MIN_DUTY floor
// to every row's duty. When it is undefined, duty 0 keeps the row dark.
module v_block_pwm #(
  parameter int unsigned V_ACTIVE_START = 37,
  parameter int unsigned BLOCK_LINES    = 72,
  parameter int unsigned NUM_ROWS       = 15,
  parameter int unsigned MIN_DUTY       = 4
) (
  input  logic        iHSYNC_clk,
  input  logic        iRST_n,
  input  logic [11:0] iV_Count,
  input  logic [6:0]  iV_Block_Duty_Count,
  input  logic        iDuty_we,
  input  logic [3:0]  iDuty_addr,
  input  logic [6:0]  iDuty_data,
  output logic [3:0]  oRow_Index,
  output logic        oRow_Valid,
  output logic        oPWM,
  output logic        oFrame_Done
);

`ifdef V_BLOCK_PWM_MIN_DUTY_EN
  localparam bit FLOOR_EN = 1'b1;
`else
  localparam bit FLOOR_EN = 1'b0;
`endif

  localparam logic [11:0] V_START     = 12'(V_ACTIVE_START);
  localparam logic [6:0]  LAST_PHASE  = 7'(BLOCK_LINES - 1);
  localparam logic [6:0]  DUTY_CEIL   = 7'(BLOCK_LINES);
  localparam logic [6:0]  DUTY_FLOOR  = FLOOR_EN ? 7'(MIN_DUTY) : 7'd0;
  localparam logic [3:0]  LAST_ROW    = 4'(NUM_ROWS - 1);
  localparam logic [4:0]  NUM_ROWS_W  = 5'(NUM_ROWS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  row_q;
  logic        valid_q;
  logic        pwm_q;
  logic        done_q;

  // Duty storage: two banks, ptr_q selects the one being displayed.
  logic [6:0]  bank_q [2][NUM_ROWS];
  logic [6:0]  bank_d [2][NUM_ROWS];
  logic        ptr_q;
  logic        ptr_d;

  logic        frame_start;
  logic        wr_ok;
  logic [6:0]  stored_duty;
  logic [6:0]  floored_duty;
  logic [6:0]  eff_duty;
  logic        pwm_hit;
  logic        last_phase;

  assign frame_start = (iV_Count == '0);
  assign wr_ok       = iDuty_we && ({1'b0, iDuty_addr} < NUM_ROWS_W);
  assign last_phase  = (iV_Block_Duty_Count == LAST_PHASE);

  // Bank swap at frame start, then refresh the new shadow from the new
  // active bank so rows not rewritten this frame keep their duty. A write
  // on the frame-start edge targets the new shadow and overrides the copy.
  always_comb begin
    bank_d = bank_q;
    ptr_d  = ptr_q;
    if (frame_start) begin
      ptr_d         = ~ptr_q;
      bank_d[ptr_q] = bank_q[~ptr_q];
    end
    if (wr_ok) begin
      for (int unsigned r = 0; r < NUM_ROWS; r++) begin
        if (iDuty_addr == 4'(r)) begin
          bank_d[~ptr_d][r] = iDuty_data;
        end
      end
    end
  end

  // Duty table register file and bank pointer.
  always_ff @(posedge iHSYNC_clk or negedge iRST_n) begin
    if (!iRST_n) begin
      bank_q <= '{default: '0};
      ptr_q  <= 1'b0;
    end else begin
      bank_q <= bank_d;
      ptr_q  <= ptr_d;
    end
  end

  // Effective duty of the row being scanned: optional floor, then clamp.
  always_comb begin
    stored_duty = '0;
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      if (row_q == 4'(r)) begin
        stored_duty = bank_q[ptr_q][r];
      end
    end
    floored_duty = (stored_duty < DUTY_FLOOR) ? DUTY_FLOOR : stored_duty;
    eff_duty     = (floored_duty > DUTY_CEIL) ? DUTY_CEIL : floored_duty;
    pwm_hit      = (iV_Block_Duty_Count < eff_duty);
  end

  // Row scan FSM with registered outputs; frame start overrides every state.
  always_ff @(posedge iHSYNC_clk or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      valid_q <= 1'b0;
      pwm_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (frame_start) begin
        state_q <= S_IDLE;
        row_q   <= '0;
        valid_q <= 1'b0;
        pwm_q   <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            valid_q <= 1'b0;
            pwm_q   <= 1'b0;
            if (iV_Count == V_START) begin
              state_q <= S_SCAN;
              row_q   <= '0;
              valid_q <= 1'b1;
            end
          end
          S_SCAN: begin
            if (iV_Count < V_START) begin
              state_q <= S_IDLE;
              row_q   <= '0;
              valid_q <= 1'b0;
              pwm_q   <= 1'b0;
            end else begin
              valid_q <= 1'b1;
              pwm_q   <= pwm_hit;
              if (last_phase) begin
                if (row_q == LAST_ROW) begin
                  state_q <= S_DONE;
                  valid_q <= 1'b0;
                  pwm_q   <= 1'b0;
                  done_q  <= 1'b1;
                end else begin
                  row_q <= row_q + 4'd1;
                end
              end
            end
          end
          S_DONE: begin
            row_q   <= LAST_ROW;
            valid_q <= 1'b0;
            pwm_q   <= 1'b0;
          end
          default: begin
            state_q <= S_IDLE;
            row_q   <= '0;
            valid_q <= 1'b0;
            pwm_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign oRow_Index  = row_q;
  assign oRow_Valid  = valid_q;
  assign oPWM        = pwm_q;
  assign oFrame_Done = done_q;

endmodule

// File: tb/tb_v_block_pwm.sv
// Bench for v_block_pwm: reference model of the zone-row scan and the
// active/shadow duty tables, compared every cycle, plus pinned literals.
module tb_v_block_pwm;

  localparam int VSTART = 37;
  localparam int BL     = 72;
  localparam int NR     = 15;
  localparam int MIND   = 4;
  localparam int FLEN   = 1125;
`ifdef V_BLOCK_PWM_MIN_DUTY_EN
  localparam int FLOOR_ON = 1;
`else
  localparam int FLOOR_ON = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic [11:0] vc;
  logic [6:0]  ph;
  logic        we;
  logic [3:0]  addr;
  logic [6:0]  data;
  logic [3:0]  row;
  logic        valid;
  logic        pwm;
  logic        done;

  int n_assert = 0;
  int n_fail   = 0;

  v_block_pwm #(
    .V_ACTIVE_START(VSTART),
    .BLOCK_LINES   (BL),
    .NUM_ROWS      (NR),
    .MIN_DUTY      (MIND)
  ) dut (
    .iHSYNC_clk         (clk),
    .iRST_n             (rst_n),
    .iV_Count           (vc),
    .iV_Block_Duty_Count(ph),
    .iDuty_we           (we),
    .iDuty_addr         (addr),
    .iDuty_data         (data),
    .oRow_Index         (row),
    .oRow_Valid         (valid),
    .oPWM               (pwm),
    .oFrame_Done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_act [NR];
  int m_sh  [NR];
  int m_mode;   // 0 idle, 1 scanning, 2 finished
  int m_row, m_valid, m_pwm, m_done;

  function automatic int eff(input int d);
    int e = d;
    if (FLOOR_ON != 0 && e < MIND) e = MIND;
    if (e > BL) e = BL;
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) begin
        m_act[i] <= 0;
        m_sh[i]  <= 0;
      end
      m_mode <= 0; m_row <= 0; m_valid <= 0; m_pwm <= 0; m_done <= 0;
    end else begin
      m_done <= 0;
      if (int'(vc) == 0) begin
        m_act <= m_sh;
        m_mode <= 0; m_row <= 0; m_valid <= 0; m_pwm <= 0;
      end else if (m_mode == 0) begin
        m_valid <= 0; m_pwm <= 0;
        if (int'(vc) == VSTART) begin
          m_mode <= 1; m_row <= 0; m_valid <= 1;
        end
      end else if (m_mode == 1) begin
        if (int'(vc) < VSTART) begin
          m_mode <= 0; m_row <= 0; m_valid <= 0; m_pwm <= 0;
        end else begin
          m_valid <= 1;
          m_pwm <= (int'(ph) < eff(m_act[m_row])) ? 1 : 0;
          if (int'(ph) == BL - 1) begin
            if (m_row == NR - 1) begin
              m_mode <= 2; m_valid <= 0; m_pwm <= 0; m_done <= 1;
            end else begin
              m_row <= m_row + 1;
            end
          end
        end
      end else begin
        m_valid <= 0; m_pwm <= 0;
      end
      if (we && int'(addr) < NR) m_sh[addr] <= int'(data);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("row",   int'(row),   m_row);
    chk("valid", int'(valid), m_valid);
    chk("pwm",   int'(pwm),   m_pwm);
    chk("done",  int'(done),  m_done);
  end

  // ---------------- stimulus ----------------
  function automatic int phase_of(input int c);
    return (c < 38) ? 0 : (c - 38) % BL;
  endfunction

  task automatic tick(input int v, input int p, input bit w, input int a, input int d);
    @(negedge clk);
    vc   = 12'(v);
    ph   = 7'(p);
    we   = w;
    addr = 4'(a);
    data = 7'(d);
    @(posedge clk);
    #1;
  endtask

  // Hand-computed expectations; phase k of row r is sampled at count 38+72*r+k.
  task automatic lit(input int tag, input int c);
    if (tag == 0 && c == 100) chk("scan_before_reset", int'(valid), 1);
    if (tag == 11 && c == 38 + 5) chk("no_duty_dark", int'(pwm), 0);
    if (tag == 1) begin
      if (c == 37)  begin chk("enter_valid", int'(valid), 1); chk("enter_pwm", int'(pwm), 0); end
      if (c == 47)  chk("r0_ph9_on", int'(pwm), 1);
      if (c == 48)  chk("r0_ph10_off", int'(pwm), 0);
      if (c == 53)  chk("r0_old_duty", int'(pwm), 0);
      if (c == 108) chk("r0_ph70_row", int'(row), 0);
      if (c == 109) chk("row_step", int'(row), 1);
      if (c == 110) chk("r1_ph0_on", int'(pwm), 1);
      if (c == 181) chk("r1_ph71_on", int'(pwm), 1);
      if (c == 232) chk("r2_clamp_on", int'(pwm), 1);
      if (c == 1116) chk("r14_row", int'(row), 14);
      if (c == 1117) begin chk("frame_done", int'(done), 1); chk("done_valid", int'(valid), 0); end
      if (c == 1118) begin chk("done_pulse_end", int'(done), 0); chk("done_row", int'(row), 14); end
    end
    if (tag == 2) begin
      if (c == 53)  chk("r0_new_duty", int'(pwm), 1);
      if (c == 58)  chk("r0_ph20_off", int'(pwm), 0);
      if (c == 256) chk("r3_ph2_floor", int'(pwm), FLOOR_ON);
      if (c == 260) chk("r3_ph6_off", int'(pwm), 0);
    end
    if (tag == 3 && c == 264) chk("fs_write_not_yet", int'(pwm), 0);
    if (tag == 4 && c == 264) chk("fs_write_later", int'(pwm), 1);
    if (tag == 5 && c == 407) begin chk("pre_vsync_row", int'(row), 5); chk("pre_vsync_valid", int'(valid), 1); end
    if (tag == 6) begin
      if (c == 0) begin
        chk("vsync_row", int'(row), 0);
        chk("vsync_valid", int'(valid), 0);
        chk("vsync_pwm", int'(pwm), 0);
        chk("vsync_done", int'(done), 0);
      end
      if (c == 53) chk("bad_addr_ignored", int'(pwm), 1);
    end
    if (tag == 7) begin
      if (c == 199) chk("pre_glitch_valid", int'(valid), 1);
      if (c == 200) begin chk("glitch_valid", int'(valid), 0); chk("glitch_row", int'(row), 0); end
    end
  endtask

  task automatic frame(input int tag, input int len, input bit rnd);
    for (int c = 0; c < len; c++) begin
      int v = c;
      bit w = 1'b0;
      int a = 0;
      int d = 0;
      if (rnd && $urandom_range(3) == 0) begin
        w = 1'b1; a = $urandom_range(15); d = $urandom_range(127);
      end
      if (tag == 1 && c == 50)  begin w = 1'b1; a = 0;  d = 20; end
      if (tag == 3 && c == 0)   begin w = 1'b1; a = 3;  d = 50; end
      if (tag == 5 && c == 300) begin w = 1'b1; a = 15; d = 99; end
      if (tag == 7 && c == 200) v = 10;
      tick(v, phase_of(c), w, a, d);
      lit(tag, c);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    vc = '0; ph = '0; we = 1'b0; addr = '0; data = '0;
    repeat (3) @(negedge clk);
    chk("rst_row", int'(row), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_pwm", int'(pwm), 0);
    chk("rst_done", int'(done), 0);
    rst_n = 1'b1;

    // Reset asserted asynchronously in the middle of a row.
    frame(0, 101, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(valid), 0);
    chk("async_rst_row", int'(row), 0);
    chk("async_rst_pwm", int'(pwm), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    frame(10, FLEN, 1'b0);
    frame(11, FLEN, 1'b0);

    // Load rows 0..2 while finished, ahead of the next frame start.
    tick(1124, 0, 1'b1, 0, 10);
    tick(1124, 0, 1'b1, 1, 72);
    tick(1124, 0, 1'b1, 2, 100);

    frame(1, FLEN, 1'b0);
    frame(2, FLEN, 1'b0);
    frame(3, FLEN, 1'b0);
    frame(4, FLEN, 1'b0);
    frame(5, 408, 1'b0);
    frame(6, FLEN, 1'b0);
    frame(7, FLEN, 1'b0);

    for (int f = 0; f < 6; f++) begin
      int len = ($urandom_range(3) == 0) ? $urandom_range(1117, 40) : FLEN;
      frame(20 + f, len, 1'b1);
    end
    repeat (4) tick(0, 0, 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
